// File: rtl/knn_pkg.sv
// Shared types and sizing helpers for the KNN majority-vote stage.
package knn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    SELECT = 2'd2,
    DONE   = 2'd3
  } state_e;

  function automatic int num_classes(input int type_w);
    return 1 << type_w;
  endfunction

  function automatic int cnt_width(input int k);
    return $clog2(k + 1);
  endfunction

  function automatic int idx_width(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/knn_vote_argmax.sv
// Sequential argmax over per-class vote counts, one class per step.
// Ties go to the class whose first vote came from the nearer neighbour.
module knn_vote_argmax #(
  parameter int TYPE_W = 3,
  parameter int CNT_W  = 3,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              step,
  input  logic [TYPE_W-1:0] cls,
  input  logic [CNT_W-1:0]  cnt,
  input  logic [IDX_W-1:0]  first_idx,
  output logic [TYPE_W-1:0] winner,
  output logic              found
);

  logic [CNT_W-1:0]  best_cnt_q, best_cnt_d;
  logic [IDX_W-1:0]  best_idx_q, best_idx_d;
  logic [TYPE_W-1:0] winner_q, winner_d;
  logic              found_q, found_d;
  logic              better;

  always_comb begin
    best_cnt_d = best_cnt_q;
    best_idx_d = best_idx_q;
    winner_d   = winner_q;
    found_d    = found_q;
    // Zero-count classes never qualify, so found stays low if nobody voted.
    better = (cnt != '0) &&
             (!found_q || (cnt > best_cnt_q) ||
              ((cnt == best_cnt_q) && (first_idx < best_idx_q)));
    if (clear) begin
      best_cnt_d = '0;
      best_idx_d = '0;
      winner_d   = '0;
      found_d    = 1'b0;
    end else if (step && better) begin
      best_cnt_d = cnt;
      best_idx_d = first_idx;
      winner_d   = cls;
      found_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      best_cnt_q <= '0;
      best_idx_q <= '0;
      winner_q   <= '0;
      found_q    <= 1'b0;
    end else begin
      best_cnt_q <= best_cnt_d;
      best_idx_q <= best_idx_d;
      winner_q   <= winner_d;
      found_q    <= found_d;
    end
  end

  assign winner = winner_q;
  assign found  = found_q;

endmodule

// File: rtl/knn_vote.sv
// Majority vote over the K nearest sorted neighbours; emits the winning class.
// Optional distance thresholding is enabled with `define KNN_DIST_THRESH_EN.
module knn_vote
  import knn_pkg::*;
#(
  parameter int L      = 4,
  parameter int W      = 16,
  parameter int TYPE_W = 3,
  parameter int K      = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_sort,
  input  logic [W*(1<<L)-1:0]         distance_array_sorted,
  input  logic [TYPE_W*(1<<L)-1:0]    type_array_sorted,
  input  logic [W-1:0]                dist_thresh,
  output logic [TYPE_W-1:0]           class_out,
  output logic                        class_valid,
  output logic                        no_match,
  output logic                        busy,
  output logic                        overrun
);

  localparam int N     = 1 << L;
  localparam int C     = num_classes(TYPE_W);
  localparam int CNT_W = cnt_width(K);
  localparam int IDX_W = idx_width(K);

  if ((K < 1) || (K > N)) begin : g_bad_k
    $error("knn_vote: K must satisfy 1 <= K <= N");
  end

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TYPE_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q   [C];
  logic [CNT_W-1:0]  cnt_d   [C];
  logic [IDX_W-1:0]  first_q [C];
  logic [IDX_W-1:0]  first_d [C];
  logic [TYPE_W-1:0] type_q  [K];
  logic [TYPE_W-1:0] type_d  [K];
  logic              elig_q  [K];
  logic              elig_d  [K];
  logic [TYPE_W-1:0] class_out_q, class_out_d;
  logic              class_valid_q, class_valid_d;
  logic              no_match_q, no_match_d;
  logic              overrun_q, overrun_d;
  logic [TYPE_W-1:0] cur_type;
  logic              am_clear, am_step, am_found;
  logic [TYPE_W-1:0] am_winner;
  logic              unused_inputs;

  // Only the first K entries matter; remaining bits are intentionally dropped.
  assign unused_inputs = ^{distance_array_sorted, dist_thresh, type_array_sorted};

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    sel_d         = sel_q;
    cnt_d         = cnt_q;
    first_d       = first_q;
    type_d        = type_q;
    elig_d        = elig_q;
    class_out_d   = class_out_q;
    class_valid_d = 1'b0;
    no_match_d    = no_match_q;
    overrun_d     = valid_sort && (state_q != IDLE);
    am_clear      = 1'b0;
    am_step       = 1'b0;
    cur_type      = type_q[idx_q];

    unique case (state_q)
      IDLE: begin
        if (valid_sort) begin
          for (int i = 0; i < K; i++) begin
            type_d[i] = type_array_sorted[TYPE_W*i +: TYPE_W];
`ifdef KNN_DIST_THRESH_EN
            elig_d[i] = (distance_array_sorted[W*i +: W] <= dist_thresh);
`else
            elig_d[i] = 1'b1;
`endif
          end
          for (int c = 0; c < C; c++) begin
            cnt_d[c]   = '0;
            first_d[c] = '0;
          end
          idx_d    = '0;
          am_clear = 1'b1;
          state_d  = COUNT;
        end
      end
      COUNT: begin
        if (elig_q[idx_q]) begin
          if (cnt_q[cur_type] == '0) first_d[cur_type] = idx_q;
          cnt_d[cur_type] = cnt_q[cur_type] + CNT_W'(1);
        end
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(K - 1)) begin
          sel_d   = '0;
          state_d = SELECT;
        end
      end
      SELECT: begin
        am_step = 1'b1;
        sel_d   = sel_q + TYPE_W'(1);
        if (sel_q == TYPE_W'(C - 1)) state_d = DONE;
      end
      DONE: begin
        class_valid_d = 1'b1;
        class_out_d   = am_found ? am_winner : '0;
`ifdef KNN_DIST_THRESH_EN
        no_match_d    = !am_found;
`else
        no_match_d    = 1'b0;
`endif
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  knn_vote_argmax #(
    .TYPE_W (TYPE_W),
    .CNT_W  (CNT_W),
    .IDX_W  (IDX_W)
  ) u_argmax (
    .clk       (clk),
    .rst       (rst),
    .clear     (am_clear),
    .step      (am_step),
    .cls       (sel_q),
    .cnt       (cnt_q[sel_q]),
    .first_idx (first_q[sel_q]),
    .winner    (am_winner),
    .found     (am_found)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      sel_q         <= '0;
      cnt_q         <= '{default: '0};
      first_q       <= '{default: '0};
      class_out_q   <= '0;
      class_valid_q <= 1'b0;
      no_match_q    <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      sel_q         <= sel_d;
      cnt_q         <= cnt_d;
      first_q       <= first_d;
      class_out_q   <= class_out_d;
      class_valid_q <= class_valid_d;
      no_match_q    <= no_match_d;
      overrun_q     <= overrun_d;
    end
  end

  // Captured neighbour data needs no reset: it is always rewritten before use.
  always_ff @(posedge clk) begin
    type_q <= type_d;
    elig_q <= elig_d;
  end

  assign class_out   = class_out_q;
  assign class_valid = class_valid_q;
  assign no_match    = no_match_q;
  assign busy        = (state_q != IDLE);
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_knn_vote.sv
// Scoreboard bench for knn_vote (K=5, TYPE_W=3, L=4, W=16).
module tb_knn_vote;

  localparam int L      = 4;
  localparam int W      = 16;
  localparam int TYPE_W = 3;
  localparam int K      = 5;
  localparam int N      = 1 << L;
  localparam int LAT    = K + (1 << TYPE_W) + 1;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     valid_sort = 1'b0;
  logic [W*N-1:0]           dist_arr = '0;
  logic [TYPE_W*N-1:0]      type_arr = '0;
  logic [W-1:0]             dist_thresh = '0;
  logic [TYPE_W-1:0]        class_out;
  logic                     class_valid;
  logic                     no_match;
  logic                     busy;
  logic                     overrun;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ovr_cnt = 0;
  int cv_cnt  = 0;
  logic prev_cv = 1'b0;

  int exp_cls_q[$];
  int exp_nm_q[$];
  int t0_q[$];

  knn_vote #(.L(L), .W(W), .TYPE_W(TYPE_W), .K(K)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .valid_sort            (valid_sort),
    .distance_array_sorted (dist_arr),
    .type_array_sorted     (type_arr),
    .dist_thresh           (dist_thresh),
    .class_out             (class_out),
    .class_valid           (class_valid),
    .no_match              (no_match),
    .busy                  (busy),
    .overrun               (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Output monitor: pops the scoreboard on every class_valid.
  always @(negedge clk) begin
    if (overrun) ovr_cnt++;
    if (class_valid) begin
      cv_cnt++;
      check("cv_width", int'(prev_cv), 0);
      if (exp_cls_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        int e_cls, e_nm, t0;
        e_cls = exp_cls_q.pop_front();
        e_nm  = exp_nm_q.pop_front();
        t0    = t0_q.pop_front();
        check("class_out", int'(class_out), e_cls);
        check("no_match", int'(no_match), e_nm);
        check("latency", cyc - t0, LAT);
      end
    end
    prev_cv = class_valid;
  end

  function automatic logic [TYPE_W*N-1:0] pack_types(input int t0, t1, t2, t3, t4, fill);
    logic [TYPE_W*N-1:0] v;
    int t[5];
    t = '{t0, t1, t2, t3, t4};
    for (int i = 0; i < N; i++)
      v[TYPE_W*i +: TYPE_W] = (i < 5) ? TYPE_W'(t[i]) : TYPE_W'(fill);
    return v;
  endfunction

  function automatic logic [W*N-1:0] pack_dists(input int d0, d1, d2, d3, d4);
    logic [W*N-1:0] v;
    int d[5];
    d = '{d0, d1, d2, d3, d4};
    for (int i = 0; i < N; i++)
      v[W*i +: W] = (i < 5) ? W'(d[i]) : W'(16'hFFFF);
    return v;
  endfunction

  task automatic send(input logic [TYPE_W*N-1:0] types, input logic [W*N-1:0] dists,
                      input int exp_cls, input int exp_nm, input bit push);
    @(posedge clk); #1;
    type_arr   = types;
    dist_arr   = dists;
    valid_sort = 1'b1;
    if (push) begin
      exp_cls_q.push_back(exp_cls);
      exp_nm_q.push_back(exp_nm);
      t0_q.push_back(cyc + 1);
    end
    @(posedge clk); #1;
    valid_sort = 1'b0;
  endtask

  task automatic wait_drain(input int held_cls);
    for (int i = 0; i < 4 * LAT; i++) begin
      @(posedge clk); #1;
      if (exp_cls_q.size() == 0) break;
    end
    check("drain", exp_cls_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    check("class_held", int'(class_out), held_cls);
  endtask

  initial begin
    logic [W*N-1:0] near_d;
    near_d = pack_dists(1, 2, 3, 4, 5);

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_class_out", int'(class_out), 0);
    check("rst_class_valid", int'(class_valid), 0);
    check("rst_no_match", int'(no_match), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    rst = 1'b1;

    // Plain majority
    send(pack_types(2, 2, 5, 2, 1, 0), near_d, 2, 0, 1'b1);
    check("busy_in_job", int'(busy), 1);
    wait_drain(2);

    // Two-way tie broken by nearest first vote
    send(pack_types(3, 4, 4, 3, 6, 0), near_d, 3, 0, 1'b1);
    wait_drain(3);

    // All distinct, entries beyond K ignored
    send(pack_types(7, 1, 2, 3, 0, 4), near_d, 7, 0, 1'b1);
    wait_drain(7);

    // Higher count beats nearer class; class 0 can win
    send(pack_types(1, 2, 2, 2, 1, 1), near_d, 2, 0, 1'b1);
    wait_drain(2);
    send(pack_types(0, 0, 5, 5, 0, 5), near_d, 0, 0, 1'b1);
    wait_drain(0);

    // Overrun: second valid_sort 3 cycles after the first
    ovr_cnt = 0;
    cv_cnt  = 0;
    send(pack_types(2, 2, 5, 2, 1, 0), near_d, 2, 0, 1'b1);
    @(posedge clk);
    send(pack_types(6, 6, 6, 6, 6, 6), near_d, 6, 0, 1'b0);
    wait_drain(2);
    check("overrun_pulses", ovr_cnt, 1);
    check("single_result", cv_cnt, 1);

    // Reset in COUNT abandons the job
    ovr_cnt = 0;
    send(pack_types(5, 5, 5, 1, 1, 0), near_d, 5, 0, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cls_q.delete();
    exp_nm_q.delete();
    t0_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    check("midrst_class_out", int'(class_out), 0);
    check("midrst_class_valid", int'(class_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_overrun", int'(overrun), 0);
    send(pack_types(6, 6, 6, 0, 0, 0), near_d, 6, 0, 1'b1);
    wait_drain(6);
    check("no_stray_overrun", ovr_cnt, 0);

`ifdef KNN_DIST_THRESH_EN
    dist_thresh = 16'd100;
    send(pack_types(1, 2, 2, 2, 2, 2), pack_dists(50, 120, 130, 140, 150), 1, 0, 1'b1);
    wait_drain(1);
    dist_thresh = 16'd10;
    send(pack_types(1, 2, 2, 2, 2, 2), pack_dists(50, 120, 130, 140, 150), 0, 1, 1'b1);
    wait_drain(0);
    check("no_match_held", int'(no_match), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
